aes_128_core_sched: RTL and testbench
=====================================

Name: aes_128_core_sched

Overview:
- Shares one AES-128 core (3-cycle round, 3-cycle output burst) among N requesting channels using round-robin arbitration.
- Sequences each transaction: grant, input load strobe, completion wait, output drain, per-channel done pulse.
- A watchdog aborts a hung transaction by pulsing the core kill and flagging an error to the owning channel.
- Sits between the channel front-ends and the core, and drives the core's data-input/output mux select.

Parameters:
- N, 4, number of requesting channels (2..8).
- SEL_W, 2, width of sel, equal to ceil(log2 N).
- LOAD_CYC, 2, cycles core_in_en is held high per transaction (1..3).
- TIMEOUT, 40, maximum RUN-state cycles before abort (1..255; 8-bit counter).

Ports:
- clk  in  1  clock
- kill  in  1  asynchronous active-high reset
- req  in  N  per-channel request, level; held until done or err
- gnt  out  N  one-hot grant, high for the whole owned transaction
- sel  out  SEL_W  index of the granted channel; drives the core data mux
- core_in_en  out  1  core input/key load strobe
- core_kill  out  1  one-cycle synchronous kill to the core on abort
- core_out_en  in  1  core output-valid, high for a contiguous burst
- done  out  N  one-cycle pulse on the channel whose block completed
- err  out  N  one-cycle pulse on the channel whose block timed out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (kill high, asynchronous): state is IDLE. gnt, sel, core_in_en, core_kill, done, err and busy are all 0. The round-robin pointer ptr is 0. Load and watchdog counters are 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- FSM states: IDLE, LOAD, RUN, DRAIN, ABORT.
- IDLE: if req is nonzero at a clk edge, grant the first requesting index searching ptr, ptr+1, ... wrapping modulo N.
  - On that same edge: gnt is set to one-hot, sel is set to the index, core_in_en goes to 1, load counter is cleared, state goes to LOAD.
- LOAD: core_in_en stays high for exactly LOAD_CYC cycles, then drops. State goes to RUN with watchdog cleared.
- RUN: watchdog increments every cycle.
  - If core_out_en is 1, go to DRAIN.
  - Otherwise, when watchdog reaches TIMEOUT-1, go to ABORT.
  - If core_out_en is high on the same cycle the watchdog reaches its limit, DRAIN wins.
- DRAIN: stay while core_out_en is 1. On the first cycle core_out_en is 0:
  - done[sel] pulses for one cycle.
  - gnt goes to 0.
  - ptr becomes (sel+1) mod N.
  - state goes to IDLE.
- ABORT (single cycle):
  - core_kill is 1 and err[sel] is 1 for that cycle.
  - gnt is cleared and ptr becomes (sel+1) mod N.
  - next state is IDLE.
- Back-to-back: the done/err cycle is spent in IDLE, so the earliest next grant is on the following edge (one-cycle gap between transactions).
- core_out_en is ignored in IDLE, LOAD and ABORT. A spurious pulse does not change state.
- req deasserted mid-transaction is ignored. The transaction completes and done/err still pulses on that channel.
- New req bits arriving mid-transaction wait for IDLE. There is no preemption.
- sel holds its last value in IDLE. gnt is the authoritative ownership indicator.
- Asynchronous kill mid-transaction returns to reset values immediately. No done or err is issued.

Test Plan:
- N=4, LOAD_CYC=2. req=0001 at edge 0 → gnt=0001, sel=0, core_in_en high at cycles 1–2. Core gives out_en at cycles 28–30 → done=0001 at cycle 31, gnt=0 at cycle 31, ptr=1.
- req=1111 held, core responding normally → grant order 0,1,2,3,0. Each done is on the matching one-hot bit. Exactly 1 IDLE cycle between done and the next gnt.
- After a channel-0 completion, req=0001 and req=1000 both high → channel 3 granted first (ptr=1 search), channel 0 next.
- TIMEOUT=40, core never asserts out_en → 40 RUN cycles, then core_kill=1 and err=0100 for one cycle (channel 2 owning), gnt=0. The next pending requester is granted.
- Channel 1 drops req during RUN; out_en arrives → done=0010 still pulses. Separately, a spurious core_out_en in IDLE → no state change, busy stays 0.
- kill asserted asynchronously mid-LOAD → gnt, core_in_en and busy go to 0 without waiting for a clock edge. After release with req=0010, channel 1 is granted (ptr=0 search, channel 0 idle).

Source files
------------

// File: rtl/aes_128_core_sched.sv
`default_nettype none
// ============================================================================
// Module      : aes_128_core_sched
// Description : Round-robin scheduler that time-shares one AES-128 core among
//               N channels, with load sequencing, drain tracking and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_128_core_sched #(
    parameter int N        = 4,
    parameter int SEL_W    = 2,
    parameter int LOAD_CYC = 2,
    parameter int TIMEOUT  = 40
) (
    input  logic             clk_i,
    input  logic             kill_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             core_in_en_o,
    output logic             core_kill_o,
    input  logic             core_out_en_i,
    output logic [N-1:0]     done_o,
    output logic [N-1:0]     err_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    localparam logic [1:0]       c_LOAD_LAST = 2'(LOAD_CYC - 1);
    localparam logic [7:0]       c_WD_LAST   = 8'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] c_IDX_LAST  = SEL_W'(N - 1);
    localparam logic [N-1:0]     c_ONE       = {{(N-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             in_en_q, in_en_d;
    logic             ckill_q, ckill_d;
    logic [N-1:0]     done_q, done_d;
    logic [N-1:0]     err_q, err_d;
    logic             busy_q, busy_d;
    logic [1:0]       load_q, load_d;
    logic [7:0]       wd_q, wd_d;

    logic             w_hit;
    logic [SEL_W-1:0] w_pick;
    logic [SEL_W-1:0] w_cand;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        if (v == c_IDX_LAST) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        w_hit  = 1'b0;
        w_pick = ptr_q;
        w_cand = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!w_hit && req_i[w_cand]) begin
                w_hit  = 1'b1;
                w_pick = w_cand;
            end
            w_cand = wrap_inc(w_cand);
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        in_en_d = in_en_q;
        ckill_d = 1'b0;
        done_d  = '0;
        err_d   = '0;
        load_d  = load_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (w_hit) begin
                    state_d = S_LOAD;
                    gnt_d   = c_ONE << w_pick;
                    sel_d   = w_pick;
                    in_en_d = 1'b1;
                    load_d  = '0;
                end
            end
            S_LOAD: begin
                if (load_q == c_LOAD_LAST) begin
                    state_d = S_RUN;
                    in_en_d = 1'b0;
                    wd_d    = '0;
                end else begin
                    load_d = load_q + 2'd1;
                end
            end
            S_RUN: begin
                // Output valid takes priority over a coincident watchdog expiry.
                if (core_out_en_i) begin
                    state_d = S_DRAIN;
                end else if (wd_q == c_WD_LAST) begin
                    state_d = S_ABORT;
                    ckill_d = 1'b1;
                    err_d   = gnt_q;
                    gnt_d   = '0;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (!core_out_en_i) begin
                    state_d = S_IDLE;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = wrap_inc(sel_q);
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
                ptr_d   = wrap_inc(sel_q);
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                in_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge kill_i) begin
        if (kill_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            in_en_q <= 1'b0;
            ckill_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            load_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            in_en_q <= in_en_d;
            ckill_q <= ckill_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            load_q  <= load_d;
            wd_q    <= wd_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign sel_o        = sel_q;
    assign core_in_en_o = in_en_q;
    assign core_kill_o  = ckill_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_128_core_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_128_core_sched
// Description : Directed self-checking bench for the AES core scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_128_core_sched;

    logic       clk;
    logic       kill;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       in_en;
    logic       ckill;
    logic       out_en;
    logic [3:0] done;
    logic [3:0] err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    aes_128_core_sched #(
        .N        (4),
        .SEL_W    (2),
        .LOAD_CYC (2),
        .TIMEOUT  (40)
    ) dut (
        .clk_i         (clk),
        .kill_i        (kill),
        .req_i         (req),
        .gnt_o         (gnt),
        .sel_o         (sel),
        .core_in_en_o  (in_en),
        .core_kill_o   (ckill),
        .core_out_en_i (out_en),
        .done_o        (done),
        .err_o         (err),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant, two load cycles, run_cyc idle RUN cycles, three-cycle output burst, done.
    task automatic run_txn(input int ch, input int run_cyc, input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        step();
        chk("grant_onehot", 32'(gnt), 32'(oh));
        chk("grant_sel", 32'(sel), 32'(ch));
        chk("load_in_en", 32'(in_en), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        step();
        chk("load_in_en_hold", 32'(in_en), 32'd1);
        step();
        chk("run_in_en_low", 32'(in_en), 32'd0);
        chk("run_gnt_held", 32'(gnt), 32'(oh));
        if (drop) req = 4'b0000;
        repeat (run_cyc) step();
        out_en = 1'b1;
        repeat (3) step();
        chk("drain_no_done", 32'(done), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        out_en = 1'b0;
        step();
        chk("done_pulse", 32'(done), 32'(oh));
        chk("done_gnt_clear", 32'(gnt), 32'd0);
        chk("done_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        kill   = 1'b1;
        req    = 4'b0000;
        out_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_in_en", 32'(in_en), 32'd0);
        chk("rst_ckill", 32'(ckill), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        kill = 1'b0;

        // Single transaction on channel 0
        req = 4'b0001;
        run_txn(0, 25, 1'b0);

        // All channels requesting: rotation 1,2,3,0 with one idle cycle between
        req = 4'b1111;
        run_txn(1, 3, 1'b0);
        run_txn(2, 3, 1'b0);
        run_txn(3, 3, 1'b0);
        run_txn(0, 3, 1'b0);

        // ptr=1 after channel 0: channel 3 wins over channel 0
        req = 4'b1001;
        run_txn(3, 2, 1'b0);
        req = 4'b0001;
        run_txn(0, 2, 1'b0);

        // Watchdog: channel 2 owns, core never answers
        req = 4'b1100;
        step();
        chk("to_grant", 32'(gnt), 32'b0100);
        step();
        step();
        chk("to_run_in_en", 32'(in_en), 32'd0);
        repeat (39) step();
        chk("to_no_kill_yet", 32'(ckill), 32'd0);
        chk("to_busy_run", 32'(busy), 32'd1);
        chk("to_no_err_yet", 32'(err), 32'd0);
        step();
        chk("abort_ckill", 32'(ckill), 32'd1);
        chk("abort_err", 32'(err), 32'b0100);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        step();
        chk("post_abort_ckill", 32'(ckill), 32'd0);
        chk("post_abort_err", 32'(err), 32'd0);
        chk("post_abort_busy", 32'(busy), 32'd0);
        req = 4'b1000;
        run_txn(3, 4, 1'b0);

        // Channel 1 withdraws req during RUN; completion still reported
        req = 4'b0010;
        run_txn(1, 4, 1'b1);

        // Spurious core_out_en while idle
        req    = 4'b0000;
        out_en = 1'b1;
        repeat (3) step();
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_gnt", 32'(gnt), 32'd0);
        chk("spur_done", 32'(done), 32'd0);
        out_en = 1'b0;
        step();

        // Asynchronous kill mid-LOAD, then ptr must restart at 0
        req = 4'b0100;
        step();
        chk("kill_pre_gnt", 32'(gnt), 32'b0100);
        #2;
        kill = 1'b1;
        #1;
        chk("kill_gnt", 32'(gnt), 32'd0);
        chk("kill_in_en", 32'(in_en), 32'd0);
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_err", 32'(err), 32'd0);
        chk("kill_done", 32'(done), 32'd0);
        step();
        kill = 1'b0;
        req  = 4'b1010;
        run_txn(1, 3, 1'b0);
        chk("final_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
